dram_sipo_frame_ctrl: RTL
=========================

Name: dram_sipo_frame_ctrl

Overview:
Frame-level controller for the serial-in/parallel-out receive path of the DRAM controller command link. It qualifies a framed serial bit stream and sequences shifting into an internal WIDTH-bit shift register, MSB first. It checks frame length, then hands each completed word to the downstream command decoder through a single-entry valid/ready holding register. It reports frame, overrun and (optionally) parity errors.

Parameters:
WIDTH, 8, payload bits per frame (>=2)
CNT_W, $clog2(WIDTH+2), bit-counter width (derived; not overridden)

Ports:
clk  input  1  clock, all logic on posedge
rst_b  input  1  reset, asynchronous, active-low
ser_frame  input  1  high for every cycle carrying a frame bit; low between frames
ser_in  input  1  serial data, sampled when ser_frame=1
word_data  output  WIDTH  held parallel word (first received bit = MSB)
word_valid  output  1  word_data valid; held until accepted
word_ready  input  1  downstream accept; transfer when word_valid & word_ready
busy  output  1  high when state != IDLE
frame_err  output  1  one-cycle pulse: frame too short or too long
overrun  output  1  sticky: completed word dropped because holding register full
parity_err  output  1  one-cycle pulse on parity mismatch (0 without feature)
err_clr  input  1  synchronous clear of overrun

Behaviour:
- Reset (async, rst_b=0): state=IDLE, bit count=0, shift reg=0, word_data=0, word_valid=0, frame_err=0, overrun=0, parity_err=0, busy=0.
- Frame length FL = WIDTH (WIDTH+1 with parity feature). Each sampled bit shifts in: sr <= {sr[WIDTH-2:0], ser_in}. The parity bit, if present, is not shifted; it is captured separately.
- States:
  - IDLE: ser_frame=1 -> sample bit 1, cnt=1, go SHIFT. No other action.
  - SHIFT:
    - ser_frame=1 -> sample bit, cnt++.
    - When cnt reaches FL on this edge -> go CHECK.
    - ser_frame=0 with cnt<FL -> frame_err pulse next cycle, discard, go IDLE.
  - CHECK (cycle after last bit):
    - ser_frame=1 (frame too long) -> frame_err pulse, go DRAIN.
    - Otherwise, if parity enabled and mismatched -> parity_err pulse, discard.
    - Otherwise, if holding register free (word_valid=0, or word_ready=1 this cycle) -> word_data<=sr, word_valid<=1.
    - Otherwise -> overrun<=1, word dropped, existing word_data untouched.
    - All non-DRAIN cases go IDLE.
  - DRAIN: stay until ser_frame=0, then go IDLE. No sampling; no further errors.
- Latency: last frame bit sampled at edge E; CHECK occupies cycle E..E+1; word_valid=1 from edge E+1 (2 cycles after the last bit cycle). Minimum inter-frame gap is 1 low cycle (the CHECK cycle); a frame may start in the IDLE cycle that follows.
- Handshake: word_valid & word_ready clears word_valid next edge, unless a new load happens on the same edge; the load wins and word_valid stays 1. word_data is stable while word_valid=1 and not accepted.
- overrun: set has priority over err_clr on the same edge.
- frame_err and parity_err are registered, so each is high for exactly one cycle after the detecting edge.
- busy = (state != IDLE), registered from state.
- Reset mid-frame: partial word discarded, and the next frame must begin from IDLE. word_data and word_valid also reset.

Optional Feature:
DRAM_SIPO_PARITY_EN
- Defined: FL=WIDTH+1. The final bit is an even-parity bit: XOR of payload and parity bit must be 0. A mismatch pulses parity_err, and the word is not loaded and overrun is not set.
- Undefined: FL=WIDTH, no parity logic, parity_err tied 0.

Test Plan:
- WIDTH=8, no parity: ser_frame high 8 cycles, bits 1,0,1,0,0,1,0,1 -> word_data=8'hA5, word_valid=1 two cycles after last bit, held until word_ready=1 for one cycle, then 0.
- Short frame: ser_frame high 5 cycles then low -> frame_err one-cycle pulse, word_valid stays 0, busy returns 0; next 8-bit frame 8'h3C received correctly.
- Long frame: ser_frame high 11 cycles -> frame_err pulse in the cycle after CHECK, DRAIN until ser_frame low, no word loaded.
- Overrun: word_ready=0; send 8'h11 then 8'h22 back-to-back with a 1-cycle gap -> word_data stays 8'h11, overrun=1. err_clr pulse -> overrun=0. Accept at the CHECK cycle of a third frame 8'h33 -> word_data=8'h33, word_valid stays 1.
- Parity (DRAM_SIPO_PARITY_EN): 8'hA5 with parity 0 -> word loaded. 8'hA5 with parity 1 -> parity_err pulse, no word.
- Async reset asserted mid-SHIFT after 4 bits -> all outputs 0 immediately; post-reset frame 8'hFF -> word_data=8'hFF.

Source files
------------

// File: rtl/dram_sipo_frame_ctrl.sv
// dram_sipo_frame_ctrl
// Frame-level controller for the serial-in/parallel-out receive path of the
// DRAM command link. A frame is a run of consecutive cycles with ser_frame=1;
// each sampled bit is shifted MSB-first into a WIDTH-bit register. The frame
// length is checked, and completed words are handed downstream through a
// single-entry valid/ready holding register. Frame, overrun and parity errors
// are reported.
//
// Build option: define DRAM_SIPO_PARITY_EN to append one even-parity bit to
// every frame (frame length WIDTH+1). When it is undefined, frames are WIDTH
// bits long and parity_err is constant 0.

module dram_sipo_frame_ctrl #(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH + 2)
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             ser_frame,
  input  logic             ser_in,
  output logic [WIDTH-1:0] word_data,
  output logic             word_valid,
  input  logic             word_ready,
  output logic             busy,
  output logic             frame_err,
  output logic             overrun,
  output logic             parity_err,
  input  logic             err_clr
);

`ifdef DRAM_SIPO_PARITY_EN
  localparam int FL = WIDTH + 1;
`else
  localparam int FL = WIDTH;
`endif

  localparam logic [CNT_W-1:0] FL_C    = CNT_W'(FL);
  localparam logic [CNT_W-1:0] WIDTH_C = CNT_W'(WIDTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    CHECK = 2'd2,
    DRAIN = 2'd3
  } state_t;

  state_t           state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic [WIDTH-1:0] sr, sr_d;
  logic [WIDTH-1:0] word_data_d;
  logic             word_valid_d;
  logic             frame_err_d;
  logic             overrun_d;
  logic             parity_err_d;
  logic             busy_d;
  logic             hold_free;
  logic             par_bad;

`ifdef DRAM_SIPO_PARITY_EN
  logic             par_bit, par_bit_d;

  // Even parity: payload XOR parity bit must be zero.
  assign par_bad = ^{sr, par_bit};
`else
  assign par_bad = 1'b0;
`endif

  // Holding register can take a new word if empty or being drained this cycle.
  assign hold_free = ~word_valid | word_ready;

  // Next-state and datapath decode for the frame sequencer.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
    state_d      = state;
    cnt_d        = cnt;
    sr_d         = sr;
    word_data_d  = word_data;
    word_valid_d = word_valid & ~word_ready;
    frame_err_d  = 1'b0;
    parity_err_d = 1'b0;
    overrun_d    = overrun & ~err_clr;
`ifdef DRAM_SIPO_PARITY_EN
    par_bit_d    = par_bit;
`endif

    case (state)
      IDLE: begin
        if (ser_frame) begin
          sr_d    = {sr[WIDTH-2:0], ser_in};
          cnt_d   = CNT_W'(1);
          state_d = SHIFT;
        end
      end

      SHIFT: begin
        if (ser_frame) begin
`ifdef DRAM_SIPO_PARITY_EN
          // The trailing parity bit is held aside, not shifted into the word.
          if (cnt == WIDTH_C) begin
            par_bit_d = ser_in;
          end else begin
            sr_d = {sr[WIDTH-2:0], ser_in};
          end
`else
          sr_d = {sr[WIDTH-2:0], ser_in};
`endif
          cnt_d = cnt + CNT_W'(1);
          if (cnt_d == FL_C) begin
            state_d = CHECK;
          end
        end else begin
          // Frame ended early: flag it and drop the partial word.
          frame_err_d = 1'b1;
          cnt_d       = '0;
          state_d     = IDLE;
        end
      end

      CHECK: begin
        cnt_d = '0;
        if (ser_frame) begin
          // Extra bit after a full frame: too long, ignore the rest of it.
          frame_err_d = 1'b1;
          state_d     = DRAIN;
        end else begin
          state_d = IDLE;
          if (par_bad) begin
            parity_err_d = 1'b1;
          end else if (hold_free) begin
            word_data_d  = sr;
            word_valid_d = 1'b1;
          end else begin
            // Set after the err_clr default so a new overrun wins over clear.
            overrun_d = 1'b1;
          end
        end
      end

      DRAIN: begin
        if (!ser_frame) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and output registers; reset clears the partial frame and the held word.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state      <= IDLE;
      cnt        <= '0;
      sr         <= '0;
      word_data  <= '0;
      word_valid <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
      parity_err <= 1'b0;
      busy       <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register updates from pre-edge values.
      state      <= state_d;
      cnt        <= cnt_d;
      sr         <= sr_d;
      word_data  <= word_data_d;
      word_valid <= word_valid_d;
      frame_err  <= frame_err_d;
      overrun    <= overrun_d;
      parity_err <= parity_err_d;
      busy       <= busy_d;
    end
  end

`ifdef DRAM_SIPO_PARITY_EN
  // Captured parity bit of the frame in progress.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      par_bit <= 1'b0;
    end else begin
      par_bit <= par_bit_d;
    end
  end
`endif

endmodule
